// File: rtl/rom_download_pkg.sv
// Shared state encoding, FIFO entry layout and default sizing for the ROM download bridge.
package rom_download_pkg;

    localparam int unsigned DEFAULT_DEPTH      = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 25;
    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam logic [7:0]  DEFAULT_ROM_INDEX  = 8'd0;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDrain,
        StDone
    } dl_state_t;

    // Entry layout is fixed at the default word path widths.
    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } dl_entry_t;

endpackage

// File: rtl/rom_download_bridge_if.sv
// HPS ioctl side and core download side of the ROM download bridge.
// Defining ROM_DOWNLOAD_CHECKSUM_EN adds the checksum signal.
interface rom_download_bridge_if
    import rom_download_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  ioctl_download;
    logic [7:0]            ioctl_index;
    logic                  ioctl_wr;
    logic [ADDR_WIDTH-1:0] ioctl_addr;
    logic [DATA_WIDTH-1:0] ioctl_dout;
    logic                  ioctl_wait;
    logic                  dl_cs;
    logic                  dl_wr;
    logic [ADDR_WIDTH-1:0] dl_addr;
    logic [DATA_WIDTH-1:0] dl_dout;
    logic                  dl_waitReq;
    logic                  done;
    logic                  overflow;
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    logic [15:0]           checksum;
`endif

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        output dl_waitReq,
        input  ioctl_wait,
        input  dl_cs,
        input  dl_wr,
        input  dl_addr,
        input  dl_dout,
        input  done,
        input  overflow
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        input  dl_waitReq,
        output ioctl_wait,
        output dl_cs,
        output dl_wr,
        output dl_addr,
        output dl_dout,
        output done,
        output overflow
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
        , output checksum
`endif
    );

endinterface

// File: rtl/download_fifo.sv
// Synchronous FIFO buffering ROM words between the HPS and the core; DEPTH is a power of two.
module download_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 41,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PtrW:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the same cycle frees an entry.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/rom_download_bridge.sv
// ROM download bridge: filters HPS ioctl words by index, buffers them and replays them to the
// core under waitReq back-pressure. Defining ROM_DOWNLOAD_CHECKSUM_EN adds a running word sum.
module rom_download_bridge
    import rom_download_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [7:0]  ROM_INDEX  = DEFAULT_ROM_INDEX,
    parameter int unsigned WAIT_LEVEL = DEPTH - 2
) (
    input logic                  clock,
    input logic                  reset,
    rom_download_bridge_if.slave bus
);
    localparam int unsigned     CntW      = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] WaitLevel = CntW'(WAIT_LEVEL);

    dl_state_t       state_q, state_d;
    dl_entry_t       slot_q, slot_d, push_entry, fifo_rdata;
    logic            slot_valid_q, slot_valid_d;
    logic            wait_q, overflow_q;
    logic            sel, push_req, consume, slot_free, bypass, enter_active;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;

    assign sel          = bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
    assign push_req     = (state_q == StActive) & sel & bus.ioctl_wr;
    assign push_entry   = '{addr: DEFAULT_ADDR_WIDTH'(bus.ioctl_addr),
                            data: DEFAULT_DATA_WIDTH'(bus.ioctl_dout)};
    assign consume      = slot_valid_q & ~bus.dl_waitReq;
    assign slot_free    = ~slot_valid_q | consume;
    // With nothing queued a write goes straight into the slot for one-cycle latency.
    assign bypass       = push_req & fifo_empty & slot_free;
    assign fifo_push    = push_req & ~bypass;
    assign fifo_pop     = slot_free & ~fifo_empty;
    assign enter_active = (state_q == StIdle) & sel;

    download_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(dl_entry_t))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q & ~consume;
        if (fifo_pop) begin
            slot_d       = fifo_rdata;
            slot_valid_d = 1'b1;
        end else if (bypass) begin
            slot_d       = push_entry;
            slot_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (sel) state_d = StActive;
            StActive: if (!sel) state_d = StDrain;
            StDrain:  if (fifo_empty && !slot_valid_q) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.dl_cs      = 1'b0;
        bus.done       = 1'b0;
        bus.ioctl_wait = 1'b0;
        unique case (state_q)
            StActive, StDrain: begin
                bus.dl_cs      = 1'b1;
                bus.ioctl_wait = wait_q;
            end
            StDone:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q       <= '0;
            slot_valid_q <= 1'b0;
            wait_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            wait_q       <= (fifo_count >= WaitLevel);
            if (enter_active)                         overflow_q <= 1'b0;
            else if (fifo_push & fifo_full & ~fifo_pop) overflow_q <= 1'b1;
        end
    end

    assign bus.dl_wr    = slot_valid_q;
    assign bus.dl_addr  = ADDR_WIDTH'(slot_q.addr);
    assign bus.dl_dout  = DATA_WIDTH'(slot_q.data);
    assign bus.overflow = overflow_q;

`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clock) begin
        if (reset || enter_active) checksum_q <= '0;
        else if (consume)          checksum_q <= checksum_q + 16'(slot_q.data);
    end

    assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rom_download_bridge.sv
// Bench for rom_download_bridge: a table of download frames plus reset, drain-restart and
// checksum sequences; every word accepted by the core is checked against a scoreboard queue.
module tb_rom_download_bridge;
    localparam int unsigned AW    = 25;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_word_t;

    typedef struct {
        string         name;
        logic [7:0]    index;
        int            nwords;
        logic [AW-1:0] base;
        int            wreq_cycles;
        bit            ignore_wait;
        bit            chk_latency;
        bit            exp_cs;
        int            exp_delivered;
        int            exp_done;
        bit            exp_overflow;
        int            exp_wait_rise;
    } frame_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rom_download_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rom_download_bridge #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ROM_INDEX  (8'd0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    exp_word_t     sb[$];
    exp_word_t     e_mon;
    int            delivered = 0;
    int            done_cnt = 0;
    int            wait_rise = -1;
    int            t0 = 0;
    int            wreq_left = 0;
    bit            chk_latency = 1'b0;
    bit            hold_prev = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    frame_t        frames[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: scoreboard, hold stability, done framing and ioctl_wait rise time.
    always @(negedge clock) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                chk("hold_stable", {bus.dl_wr, bus.dl_addr, bus.dl_dout},
                    {1'b1, prev_addr, prev_data});
            if (bus.dl_wr && !bus.dl_waitReq) begin
                delivered++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got addr %0h data %0h, expected none",
                             bus.dl_addr, bus.dl_dout);
                end else begin
                    e_mon = sb.pop_front();
                    chk("word_addr", bus.dl_addr, e_mon.addr);
                    chk("word_data", bus.dl_dout, e_mon.data);
                    if (chk_latency) chk("word_latency", cyc, e_mon.cyc + 1);
                end
            end
            hold_prev = bus.dl_wr && bus.dl_waitReq;
            prev_addr = bus.dl_addr;
            prev_data = bus.dl_dout;
            if (bus.done) begin
                done_cnt++;
                chk("cs_low_at_done", bus.dl_cs, 1'b0);
            end
            if (bus.ioctl_wait && wait_rise < 0) wait_rise = cyc - t0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (wreq_left > 0) begin
            wreq_left--;
            if (wreq_left == 0) bus.dl_waitReq = 1'b0;
        end
    endtask

    task automatic drive_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit acc);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        if (acc) sb.push_back('{addr: a, data: d, cyc: cyc});
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int guard = 0;
        while (done_cnt < target && guard < 100) begin
            tick();
            guard++;
        end
        chk({name, "_done_seen"}, done_cnt, target);
    endtask

    task automatic run_frame(input frame_t f);
        int k = 0;
        int guard = 0;
        delivered         = 0;
        done_cnt          = 0;
        wait_rise         = -1;
        chk_latency       = f.chk_latency;
        bus.ioctl_index   = f.index;
        bus.ioctl_download = 1'b1;
        wreq_left         = f.wreq_cycles;
        bus.dl_waitReq    = (f.wreq_cycles > 0);
        tick();
        chk({f.name, "_cs_active"}, bus.dl_cs, f.exp_cs);
        if (f.exp_cs) chk({f.name, "_overflow_cleared"}, bus.overflow, 1'b0);
        t0 = cyc;
        while (k < f.nwords && guard < 200) begin
            if (f.ignore_wait || !bus.ioctl_wait) begin
                drive_word(f.base + AW'(2 * k), DW'(32'h1111 * (k + 1)), k < f.exp_delivered);
                k++;
            end else begin
                tick();
            end
            guard++;
        end
        chk({f.name, "_writes_issued"}, k, f.nwords);
        bus.ioctl_download = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 100) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        chk({f.name, "_delivered"}, delivered, f.exp_delivered);
        chk({f.name, "_done_count"}, done_cnt, f.exp_done);
        chk({f.name, "_overflow"}, bus.overflow, f.exp_overflow);
        chk({f.name, "_scoreboard_empty"}, sb.size(), 0);
        chk({f.name, "_wait_rise"}, wait_rise, f.exp_wait_rise);
        chk({f.name, "_cs_end"}, bus.dl_cs, 1'b0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        // name, index, nwords, base, wreq, ignore_wait, latency,
        // exp_cs, exp_delivered, exp_done, exp_overflow, exp_wait_rise
        frames[0] = '{"basic",         8'd0,  4, 25'h000,  0, 1'b0, 1'b1, 1'b1,  4, 1, 1'b0, -1};
        frames[1] = '{"backpressure",  8'd0,  8, 25'h100, 20, 1'b1, 1'b0, 1'b1,  8, 1, 1'b0,  8};
        frames[2] = '{"index_filter",  8'd1,  3, 25'h200,  0, 1'b0, 1'b0, 1'b0,  0, 0, 1'b0, -1};
        frames[3] = '{"overflow",      8'd0, 10, 25'h300, 30, 1'b1, 1'b0, 1'b1,  9, 1, 1'b1,  8};
        frames[4] = '{"wait_throttle", 8'd0, 12, 25'h400, 10, 1'b0, 1'b0, 1'b1, 12, 1, 1'b0,  8};
        frames[5] = '{"after_reset",   8'd0,  2, 25'h500,  0, 1'b0, 1'b1, 1'b1,  2, 1, 1'b0, -1};

        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.dl_waitReq     = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_ioctl_wait", bus.ioctl_wait, 1'b0);
        chk("reset_dl_cs", bus.dl_cs, 1'b0);
        chk("reset_dl_wr", bus.dl_wr, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_overflow", bus.overflow, 1'b0);
        chk("reset_dl_addr", bus.dl_addr, 25'h0);
        chk("reset_dl_dout", bus.dl_dout, 16'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_frame(frames[i]);

        // Reset with words buffered: everything is discarded and no done pulse appears.
        delivered          = 0;
        done_cnt           = 0;
        chk_latency        = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        bus.dl_waitReq     = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) drive_word(25'h600 + AW'(2 * k), 16'hA000 + DW'(k), 1'b0);
        tick();
        chk("prereset_wait_high", bus.ioctl_wait, 1'b1);
        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        tick();
        chk("midreset_cs", bus.dl_cs, 1'b0);
        chk("midreset_wr", bus.dl_wr, 1'b0);
        chk("midreset_wait", bus.ioctl_wait, 1'b0);
        chk("midreset_done", bus.done, 1'b0);
        reset          = 1'b0;
        bus.dl_waitReq = 1'b0;
        repeat (5) tick();
        chk("postreset_no_done", done_cnt, 0);
        chk("postreset_no_words", delivered, 0);
        run_frame(frames[5]);

        // Raising sel again during DRAIN must not restart the frame until IDLE is reached.
        delivered          = 0;
        done_cnt           = 0;
        chk_latency        = 1'b0;
        bus.ioctl_download = 1'b1;
        bus.dl_waitReq     = 1'b1;
        tick();
        drive_word(25'h700, 16'hAAAA, 1'b1);
        drive_word(25'h702, 16'hBBBB, 1'b1);
        bus.ioctl_download = 1'b0;
        tick();
        chk("drain_cs_held", bus.dl_cs, 1'b1);
        bus.ioctl_download = 1'b1;
        drive_word(25'h704, 16'hCCCC, 1'b0);
        drive_word(25'h706, 16'hDDDD, 1'b0);
        bus.dl_waitReq = 1'b0;
        wait_done(1, "drain");
        tick();
        chk("drain_restart_cs", bus.dl_cs, 1'b1);
        bus.ioctl_download = 1'b0;
        wait_done(2, "drain_second");
        chk("drain_delivered", delivered, 2);
        chk("drain_scoreboard_empty", sb.size(), 0);

`ifdef ROM_DOWNLOAD_CHECKSUM_EN
        repeat (2) tick();
        done_cnt           = 0;
        bus.ioctl_download = 1'b1;
        tick();
        drive_word(25'h800, 16'hFFFF, 1'b1);
        drive_word(25'h802, 16'h0002, 1'b1);
        bus.ioctl_download = 1'b0;
        wait_done(1, "checksum");
        tick();
        chk("checksum_value", bus.checksum, 16'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
